// File: rtl/bcd_updown_timer.sv
// bcd_updown_timer: BCD mm:ss up/down timer with saturating preset load, tc pulse and expiry.
// Define TIMER_HOURS_EN to add an hh field (00..23) in front of the minutes.
module bcd_updown_timer #(
  parameter int MIN_TENS_MAX = 5,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk_1hz,
  input  logic       reset,
  input  logic       enable,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] preset_sec_unit,
  input  logic [3:0] preset_sec_tens,
  input  logic [3:0] preset_min_unit,
  input  logic [3:0] preset_min_tens,
`ifdef TIMER_HOURS_EN
  input  logic [3:0] preset_hr_unit,
  input  logic [3:0] preset_hr_tens,
  output logic [3:0] hr_unit,
  output logic [3:0] hr_tens,
`endif
  output logic [3:0] sec_unit,
  output logic [3:0] sec_tens,
  output logic [3:0] min_unit,
  output logic [3:0] min_tens,
  output logic       tc,
  output logic       done
);
  typedef enum logic {COUNT, EXPIRED} state_t;
`ifdef TIMER_HOURS_EN
  localparam int W = 24;
`else
  localparam int W = 16;
`endif
  localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);
  state_t state;
  logic [W-1:0] cnt, ps, up, dn;
  logic [15:0] ps_lo, up_lo, dn_lo;
  logic c0, c1, c2, c3, b0, b1, b2, b3;
  logic upper_zero, wrap, zero, dn_hit;
  function automatic logic [3:0] sat(input logic [3:0] d, input logic [3:0] m);
    return d > m ? m : d;
  endfunction
  assign {min_tens, min_unit, sec_tens, sec_unit} = cnt[15:0];
  // c* are the up-carry chain, b* the down-borrow chain, lowest digit first
  always_comb begin
    c0 = sec_unit == 4'd9;
    c1 = c0 && sec_tens == 4'd5;
    c2 = c1 && min_unit == 4'd9;
    c3 = c2 && min_tens == MT_MAX;
    b0 = sec_unit == 4'd0;
    b1 = b0 && sec_tens == 4'd0;
    b2 = b1 && min_unit == 4'd0;
    b3 = b2 && min_tens == 4'd0;
    ps_lo = {sat(preset_min_tens, MT_MAX), sat(preset_min_unit, 4'd9),
             sat(preset_sec_tens, 4'd5), sat(preset_sec_unit, 4'd9)};
    up_lo = {c3 ? 4'd0 : c2 ? min_tens + 4'd1 : min_tens,
             c2 ? 4'd0 : c1 ? min_unit + 4'd1 : min_unit,
             c1 ? 4'd0 : c0 ? sec_tens + 4'd1 : sec_tens,
             c0 ? 4'd0 : sec_unit + 4'd1};
    dn_lo = {b3 ? MT_MAX : b2 ? min_tens - 4'd1 : min_tens,
             b2 ? 4'd9 : b1 ? min_unit - 4'd1 : min_unit,
             b1 ? 4'd5 : b0 ? sec_tens - 4'd1 : sec_tens,
             b0 ? 4'd9 : sec_unit - 4'd1};
  end
`ifdef TIMER_HOURS_EN
  logic [7:0] ps_hi, up_hi, dn_hi;
  logic h_top;
  assign {hr_tens, hr_unit} = cnt[23:16];
  assign ps = {ps_hi, ps_lo};
  assign up = {up_hi, up_lo};
  assign dn = {dn_hi, dn_lo};
  assign upper_zero = cnt[23:4] == '0;
  assign wrap = c3 && h_top;
  // the hour borrow from 00 is never taken: 00:00:00 is terminal, not a step
  always_comb begin
    h_top = hr_tens == 4'd2 && hr_unit == 4'd3;
    ps_hi = preset_hr_tens > 4'd2 ? 8'h23 :
            {preset_hr_tens, sat(preset_hr_unit, preset_hr_tens == 4'd2 ? 4'd3 : 4'd9)};
    up_hi = !c3 ? cnt[23:16] : h_top ? 8'h00 :
            hr_unit == 4'd9 ? {hr_tens + 4'd1, 4'd0} : {hr_tens, hr_unit + 4'd1};
    dn_hi = !b3 ? cnt[23:16] :
            hr_unit == 4'd0 ? {hr_tens - 4'd1, 4'd9} : {hr_tens, hr_unit - 4'd1};
  end
`else
  assign ps = ps_lo;
  assign up = up_lo;
  assign dn = dn_lo;
  assign upper_zero = cnt[15:4] == '0;
  assign wrap = c3;
`endif
  assign zero = upper_zero && b0;
  assign dn_hit = upper_zero && sec_unit == 4'd1;
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      tc <= 1'b0;
      done <= 1'b0;
      state <= COUNT;
    end else begin
      tc <= 1'b0;
      if (load) begin
        cnt <= ps;
        state <= COUNT;
        done <= 1'b0;
      end else if (state == COUNT && enable) begin
        if (up_dn) begin
          cnt <= up;
          tc <= wrap;
        end else if (!zero) begin
          cnt <= dn;
          tc <= dn_hit;
        end else if (AUTO_RELOAD) begin
          cnt <= ps;
        end else begin
          state <= EXPIRED;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_updown_timer.sv
// tb_bcd_updown_timer: directed checks of a stop-at-zero and an auto-reload timer fed the same stimulus.
module tb_bcd_updown_timer;
  logic clk_1hz = 1'b0, reset = 1'b0, enable = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [3:0] p_su = 4'd0, p_st = 4'd0, p_mu = 4'd0, p_mt = 4'd0;
  logic [3:0] a_su, a_st, a_mu, a_mt, r_su, r_st, r_mu, r_mt;
  logic a_tc, a_done, r_tc, r_done;
  logic [15:0] a_cnt, r_cnt;
  int n_pass = 0, n_total = 0, tc_hits = 0;
`ifdef TIMER_HOURS_EN
  logic [3:0] p_hu = 4'd0, p_ht = 4'd0, a_hu, a_ht, r_hu, r_ht;
`endif
  localparam logic [15:0] A_EXP [5] = '{16'h0002, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
  localparam logic [15:0] R_EXP [5] = '{16'h0002, 16'h0001, 16'h0000, 16'h0003, 16'h0002};
  localparam logic        TC_EXP [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic        DN_EXP [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic        DIRS [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [15:0] DIR_EXP [4] = '{16'h1235, 16'h1234, 16'h1233, 16'h1234};
  assign a_cnt = {a_mt, a_mu, a_st, a_su};
  assign r_cnt = {r_mt, r_mu, r_st, r_su};
  always #5 clk_1hz = ~clk_1hz;
  bcd_updown_timer #(.MIN_TENS_MAX(5), .AUTO_RELOAD(1'b0)) dut_a (
    .clk_1hz(clk_1hz), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .preset_sec_unit(p_su), .preset_sec_tens(p_st), .preset_min_unit(p_mu), .preset_min_tens(p_mt),
`ifdef TIMER_HOURS_EN
    .preset_hr_unit(p_hu), .preset_hr_tens(p_ht), .hr_unit(a_hu), .hr_tens(a_ht),
`endif
    .sec_unit(a_su), .sec_tens(a_st), .min_unit(a_mu), .min_tens(a_mt), .tc(a_tc), .done(a_done));
  bcd_updown_timer #(.MIN_TENS_MAX(5), .AUTO_RELOAD(1'b1)) dut_r (
    .clk_1hz(clk_1hz), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .preset_sec_unit(p_su), .preset_sec_tens(p_st), .preset_min_unit(p_mu), .preset_min_tens(p_mt),
`ifdef TIMER_HOURS_EN
    .preset_hr_unit(p_hu), .preset_hr_tens(p_ht), .hr_unit(r_hu), .hr_tens(r_ht),
`endif
    .sec_unit(r_su), .sec_tens(r_st), .min_unit(r_mu), .min_tens(r_mt), .tc(r_tc), .done(r_done));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk_1hz);
    #1;
  endtask
  task automatic preset(input logic [15:0] v);
    {p_mt, p_mu, p_st, p_su} = v;
  endtask
  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_cnt", a_cnt, 0);
    check("rst_tc", a_tc, 0);
    check("rst_done", a_done, 0);
    tick();
    reset = 1'b0;
    enable = 1'b1;
    repeat (60) begin
      tick();
      tc_hits += int'(a_tc);
    end
    check("up60_cnt", a_cnt, 16'h0100);
    check("up60_tc", tc_hits, 0);
    preset(16'h5959);
    load = 1'b1;
    tick();
    check("ld_5959", a_cnt, 16'h5959);
    check("ld_tc", a_tc, 0);
    load = 1'b0;
    tick();
    check("wrap_cnt", a_cnt, 16'h0000);
    check("wrap_tc", a_tc, 1);
    tick();
    check("post_wrap", a_cnt, 16'h0001);
    check("post_wrap_tc", a_tc, 0);
    preset(16'hFF78);
    load = 1'b1;
    tick();
    check("sat_ld", a_cnt, 16'h5958);
    preset(16'h1234);
    tick();
    check("ld_1234", a_cnt, 16'h1234);
    load = 1'b0;
    enable = 1'b0;
    repeat (3) begin
      tick();
      check("hold_cnt", a_cnt, 16'h1234);
      check("hold_tc", a_tc, 0);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_dn = DIRS[i];
      tick();
      check("dir_change", a_cnt, DIR_EXP[i]);
    end
    up_dn = 1'b0;
    preset(16'h1000);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("borrow", a_cnt, 16'h0959);
    preset(16'h0003);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("ld_r", r_cnt, 16'h0003);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dn_a_cnt", a_cnt, A_EXP[i]);
      check("dn_a_tc", a_tc, TC_EXP[i]);
      check("dn_a_done", a_done, DN_EXP[i]);
      check("dn_r_cnt", r_cnt, R_EXP[i]);
      check("dn_r_tc", r_tc, TC_EXP[i]);
    end
    up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("exp_done", a_done, 1);
      check("exp_cnt", a_cnt, 16'h0000);
      check("r_up", r_cnt, 16'(16'h0003 + i));
    end
    #2 reset = 1'b1;
    #1;
    check("arst_done", a_done, 0);
    check("arst_a_cnt", a_cnt, 16'h0000);
    check("arst_r_cnt", r_cnt, 16'h0000);
    reset = 1'b0;
    tick();
    check("resume_cnt", a_cnt, 16'h0001);
    check("resume_done", a_done, 0);
`ifdef TIMER_HOURS_EN
    preset(16'h5959);
    p_ht = 4'd2;
    p_hu = 4'd9;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("hr_sat", {a_ht, a_hu}, 8'h23);
    tick();
    check("hr_wrap", {a_ht, a_hu, a_cnt}, 24'h000000);
    check("hr_wrap_tc", a_tc, 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bcd_updown_timer.md
BCD_UPDOWN_TIMER -- requirements
Module: bcd_updown_timer

Interface
REQ-001 Parameter MIN_TENS_MAX, default 5, SHALL set the largest minute-tens digit (minutes span 00..MIN_TENS_MAX9); legal range 1..9.
REQ-002 Parameter AUTO_RELOAD, default 0, SHALL select the terminal action in down mode: 0 = stop at zero, 1 = reload the preset.
REQ-003 clk_1hz  in  1  count clock; every rising edge is one count step.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 enable  in  1  count enable.
REQ-006 up_dn  in  1  direction: 1 = up, 0 = down.
REQ-007 load  in  1  synchronous preset load.
REQ-008 preset_sec_unit, preset_sec_tens, preset_min_unit, preset_min_tens  in  4 each  BCD preset value.
REQ-009 sec_unit, sec_tens, min_unit, min_tens  out  4 each  registered BCD count.
REQ-010 tc  out  1  one-cycle terminal-count pulse.
REQ-011 done  out  1  level; high while in the EXPIRED state.

Function
REQ-012 FSM SHALL have two states, COUNT and EXPIRED; each state change occurs on a clk_1hz rising edge.
REQ-013 Edge priority SHALL be load, then EXPIRED hold, then enable.
REQ-014 load=1 SHALL copy the preset into the count and enter COUNT.
REQ-015 During load, any digit above its legal maximum (units 9, sec_tens 5, min_tens MIN_TENS_MAX) SHALL saturate to that maximum.
REQ-016 COUNT, enable=1, up_dn=1: the count SHALL increment as BCD, with each digit rolling to 0 and carrying into the next digit.
REQ-017 In up mode, the step from MIN_TENS_MAX9:59 SHALL wrap to 00:00, with tc=1 for that cycle.
REQ-018 COUNT, enable=1, up_dn=0: the count SHALL decrement as BCD; units borrow 0->9, sec_tens borrows 0->5.
REQ-019 In down mode, a step that reaches 00:00 SHALL assert tc for that cycle.
REQ-020 The next enabled down-step from 00:00 SHALL enter EXPIRED when AUTO_RELOAD=0, and SHALL reload the preset (saturated) and stay in COUNT when AUTO_RELOAD=1.
REQ-021 In EXPIRED, the count SHALL hold at 00:00 and done SHALL be 1, regardless of enable and up_dn; only load or reset leaves EXPIRED.
REQ-022 enable=0 in COUNT SHALL hold all digits and keep tc=0.
REQ-023 A change of up_dn SHALL take effect on the next edge, with no extra latency and no skipped or repeated value.
REQ-024 tc SHALL never be high for two consecutive cycles, and SHALL be 0 on any edge where load=1.
REQ-025 All outputs SHALL be registered; a count value SHALL appear one edge after its triggering inputs.

Reset
REQ-026 While reset=1, all digits SHALL be 0, tc=0, done=0, state=COUNT, and hr_unit/hr_tens (when compiled in) SHALL be 0, immediately and without waiting for a clock edge.
REQ-027 A reset asserted mid-count or in EXPIRED SHALL discard the state; counting SHALL resume from 00:00 at the first enabled edge after release.

Configuration
REQ-028 Macro TIMER_HOURS_EN, when defined, SHALL add outputs hr_unit and hr_tens (out, 4 each) and inputs preset_hr_unit and preset_hr_tens (in, 4 each).
REQ-029 With TIMER_HOURS_EN defined, the count SHALL span 00:00:00..23:MIN_TENS_MAX9:59, with up-wrap and down-terminal both defined at the full 00:00:00 value.
REQ-030 With TIMER_HOURS_EN defined, a loaded hour value above 23 SHALL saturate to 23.
REQ-031 Without TIMER_HOURS_EN, the hour ports and logic SHALL be absent and behaviour SHALL be exactly REQ-012..REQ-025.

Verification
REQ-032 Up count: reset, enable=1, up_dn=1, 60 edges -> 01:00 and tc never high.
REQ-033 Up wrap: load 59:59, then up one step -> 00:00 with tc=1 for one cycle.
REQ-034 Down to EXPIRED (AUTO_RELOAD=0): load 00:02, down 3 edges -> 00:01, 00:00 (tc=1), then EXPIRED with done=1 held over 5 further edges.
REQ-035 Auto-reload (AUTO_RELOAD=1): preset 00:03, down 5 edges -> 00:02, 00:01, 00:00 (tc=1), 00:03, 00:02.
REQ-036 Saturating load: preset F:F:7:8 -> loaded 59:58 (MIN_TENS_MAX=5); a load arriving together with enable wins.
REQ-037 Async reset: assert reset between edges while in EXPIRED -> outputs 0 before the next edge; with TIMER_HOURS_EN, up from 23:59:59 -> 00:00:00 with tc=1.
